// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_stage
// Purpose  : RV32I decode stage with writeback bypass, load-use stall
//            detection and the ID/EX pipeline register.
// Revision : 1.0
// ============================================================================
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        ValidD,
  output logic [4:0]  A1,
  output logic [4:0]  A2,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  input  logic        WE3W,
  input  logic [4:0]  RdW,
  input  logic [31:0] WD3W,
  input  logic        FlushE,
  output logic        StallD,
  output logic        ValidE,
  output logic        IllegalE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE,
  output logic [2:0]  Funct3E,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        JalrE,
  output logic        ALUSrcAE,
  output logic        ALUSrcBE,
  output logic [1:0]  ResultSrcE,
  output logic [3:0]  ALUControlE
);

  localparam logic [6:0] c_OP_REG = 7'b0110011;
  localparam logic [6:0] c_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_LOAD   = 7'b0000011;
  localparam logic [6:0] c_STORE  = 7'b0100011;
  localparam logic [6:0] c_BRANCH = 7'b1100011;
  localparam logic [6:0] c_JAL    = 7'b1101111;
  localparam logic [6:0] c_JALR   = 7'b1100111;
  localparam logic [6:0] c_LUI    = 7'b0110111;
  localparam logic [6:0] c_AUIPC  = 7'b0010111;

  localparam logic [3:0] c_ALU_ADD   = 4'd0;
  localparam logic [3:0] c_ALU_SUB   = 4'd1;
  localparam logic [3:0] c_ALU_SLL   = 4'd2;
  localparam logic [3:0] c_ALU_SLT   = 4'd3;
  localparam logic [3:0] c_ALU_SLTU  = 4'd4;
  localparam logic [3:0] c_ALU_XOR   = 4'd5;
  localparam logic [3:0] c_ALU_SRL   = 4'd6;
  localparam logic [3:0] c_ALU_SRA   = 4'd7;
  localparam logic [3:0] c_ALU_OR    = 4'd8;
  localparam logic [3:0] c_ALU_AND   = 4'd9;
  localparam logic [3:0] c_ALU_PASSB = 4'd10;

  localparam logic [1:0] c_RES_ALU = 2'b00;
  localparam logic [1:0] c_RES_MEM = 2'b01;
  localparam logic [1:0] c_RES_PC4 = 2'b10;

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd;
  logic        w_f7b5;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [3:0]  w_alu_f3;
  logic        w_reg_write, w_mem_write, w_branch, w_jump, w_jalr;
  logic        w_src_a, w_src_b, w_illegal, w_use1, w_use2;
  logic [1:0]  w_result_src;
  logic [3:0]  w_alu;
  logic [31:0] w_imm;
  logic [31:0] w_rs1_val, w_rs2_val;
  logic        w_stall, w_bubble;

  logic        r_valid, r_illegal, r_reg_write, r_mem_write, r_branch;
  logic        r_jump, r_jalr, r_src_a, r_src_b;
  logic [1:0]  r_result_src;
  logic [3:0]  r_alu;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rs1, r_rs2, r_rd;
  logic [31:0] r_pc, r_pc4, r_rd1, r_rd2, r_imm;

  assign w_opcode = InstrD[6:0];
  assign w_funct3 = InstrD[14:12];
  assign w_rd     = InstrD[11:7];
  assign w_f7b5   = InstrD[30];
  assign A1       = InstrD[19:15];
  assign A2       = InstrD[24:20];

  assign w_imm_i = {{20{InstrD[31]}}, InstrD[31:20]};
  assign w_imm_s = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
  assign w_imm_b = {{19{InstrD[31]}}, InstrD[31], InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
  assign w_imm_u = {InstrD[31:12], 12'b0};
  assign w_imm_j = {{11{InstrD[31]}}, InstrD[31], InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};

  // Register-file write lands at the edge, so a same-cycle writeback must be bypassed here.
  assign w_rs1_val = (WE3W && (RdW != 5'd0) && (RdW == A1)) ? WD3W : RD1;
  assign w_rs2_val = (WE3W && (RdW != 5'd0) && (RdW == A2)) ? WD3W : RD2;

  always_comb begin
    w_alu_f3 = c_ALU_ADD;
    case (w_funct3)
      3'b000:  w_alu_f3 = c_ALU_ADD;
      3'b001:  w_alu_f3 = c_ALU_SLL;
      3'b010:  w_alu_f3 = c_ALU_SLT;
      3'b011:  w_alu_f3 = c_ALU_SLTU;
      3'b100:  w_alu_f3 = c_ALU_XOR;
      3'b101:  w_alu_f3 = w_f7b5 ? c_ALU_SRA : c_ALU_SRL;
      3'b110:  w_alu_f3 = c_ALU_OR;
      default: w_alu_f3 = c_ALU_AND;
    endcase
  end

  always_comb begin
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_branch     = 1'b0;
    w_jump       = 1'b0;
    w_jalr       = 1'b0;
    w_src_a      = 1'b0;
    w_src_b      = 1'b0;
    w_illegal    = 1'b0;
    w_use1       = 1'b0;
    w_use2       = 1'b0;
    w_result_src = c_RES_ALU;
    w_alu        = c_ALU_ADD;
    w_imm        = 32'd0;
    case (w_opcode)
      c_OP_REG: begin
        w_reg_write = 1'b1;
        w_use1      = 1'b1;
        w_use2      = 1'b1;
        w_alu       = (w_funct3 == 3'b000 && w_f7b5) ? c_ALU_SUB : w_alu_f3;
      end
      c_OP_IMM: begin
        w_reg_write = 1'b1;
        w_use1      = 1'b1;
        w_src_b     = 1'b1;
        w_imm       = w_imm_i;
        w_alu       = w_alu_f3;
      end
      c_LOAD: begin
        w_reg_write  = 1'b1;
        w_use1       = 1'b1;
        w_src_b      = 1'b1;
        w_imm        = w_imm_i;
        w_result_src = c_RES_MEM;
      end
      c_STORE: begin
        w_mem_write = 1'b1;
        w_use1      = 1'b1;
        w_use2      = 1'b1;
        w_src_b     = 1'b1;
        w_imm       = w_imm_s;
      end
      c_BRANCH: begin
        w_branch = 1'b1;
        w_use1   = 1'b1;
        w_use2   = 1'b1;
        w_imm    = w_imm_b;
        w_alu    = c_ALU_SUB;
      end
      c_JAL: begin
        w_jump       = 1'b1;
        w_reg_write  = 1'b1;
        w_src_a      = 1'b1;
        w_src_b      = 1'b1;
        w_imm        = w_imm_j;
        w_result_src = c_RES_PC4;
      end
      c_JALR: begin
        w_jump       = 1'b1;
        w_jalr       = 1'b1;
        w_reg_write  = 1'b1;
        w_use1       = 1'b1;
        w_src_b      = 1'b1;
        w_imm        = w_imm_i;
        w_result_src = c_RES_PC4;
      end
      c_LUI: begin
        w_reg_write = 1'b1;
        w_src_b     = 1'b1;
        w_imm       = w_imm_u;
        w_alu       = c_ALU_PASSB;
      end
      c_AUIPC: begin
        w_reg_write = 1'b1;
        w_src_a     = 1'b1;
        w_src_b     = 1'b1;
        w_imm       = w_imm_u;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // A load in E whose destination feeds a live source of D needs one bubble.
  assign w_stall = ValidD && r_reg_write && (r_result_src == c_RES_MEM) && (r_rd != 5'd0) &&
                   ((w_use1 && (A1 == r_rd)) || (w_use2 && (A2 == r_rd)));
  assign w_bubble = FlushE || w_stall || !ValidD;
  assign StallD   = w_stall;

  always_ff @(posedge clk) begin
    if (reset || w_bubble) begin
      r_valid      <= 1'b0;
      r_illegal    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_jalr       <= 1'b0;
      r_src_a      <= 1'b0;
      r_src_b      <= 1'b0;
      r_result_src <= 2'b00;
      r_alu        <= 4'd0;
      r_funct3     <= 3'd0;
      r_rs1        <= 5'd0;
      r_rs2        <= 5'd0;
      r_rd         <= 5'd0;
      r_pc         <= 32'd0;
      r_pc4        <= 32'd0;
      r_rd1        <= 32'd0;
      r_rd2        <= 32'd0;
      r_imm        <= 32'd0;
    end else begin
      r_valid      <= 1'b1;
      r_illegal    <= w_illegal;
      r_reg_write  <= w_reg_write && (w_rd != 5'd0);
      r_mem_write  <= w_mem_write;
      r_branch     <= w_branch;
      r_jump       <= w_jump;
      r_jalr       <= w_jalr;
      r_src_a      <= w_src_a;
      r_src_b      <= w_src_b;
      r_result_src <= w_result_src;
      r_alu        <= w_alu;
      r_funct3     <= w_funct3;
      r_rs1        <= A1;
      r_rs2        <= A2;
      r_rd         <= w_rd;
      r_pc         <= PCD;
      r_pc4        <= PCPlus4D;
      r_rd1        <= w_rs1_val;
      r_rd2        <= w_rs2_val;
      r_imm        <= w_imm;
    end
  end

  assign ValidE      = r_valid;
  assign IllegalE    = r_illegal;
  assign RegWriteE   = r_reg_write;
  assign MemWriteE   = r_mem_write;
  assign BranchE     = r_branch;
  assign JumpE       = r_jump;
  assign JalrE       = r_jalr;
  assign ALUSrcAE    = r_src_a;
  assign ALUSrcBE    = r_src_b;
  assign ResultSrcE  = r_result_src;
  assign ALUControlE = r_alu;
  assign Funct3E     = r_funct3;
  assign Rs1E        = r_rs1;
  assign Rs2E        = r_rs2;
  assign RdE         = r_rd;
  assign PCE         = r_pc;
  assign PCPlus4E    = r_pc4;
  assign RD1E        = r_rd1;
  assign RD2E        = r_rd2;
  assign ImmExtE     = r_imm;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage
// Purpose  : directed and randomized checks of id_stage against an encoder-side model.
// Revision : 1.0
// ============================================================================
module tb_id_stage;

  typedef struct packed {
    logic        valid, illegal, rw, mw, br, jmp, jalr, srca, srcb;
    logic        use1, use2, chk_alu, chk_srca, chk_srcb;
    logic [1:0]  rsrc;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] pc, pc4, rd1, rd2, imm;
  } e_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstrD, PCD, PCPlus4D, RD1, RD2, WD3W;
  logic        ValidD, WE3W, FlushE, StallD, ValidE, IllegalE;
  logic [4:0]  A1, A2, RdW, Rs1E, Rs2E, RdE;
  logic [31:0] PCE, PCPlus4E, RD1E, RD2E, ImmExtE;
  logic [2:0]  Funct3E;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;

  int n_checks = 0;
  int n_errors = 0;
  int alu_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  e_t          m_e, d_desc, nxt;
  logic [31:0] ins, b1, b2;
  logic        hold, exp_stall;

  id_stage dut (
    .clk(clk), .reset(reset), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .WE3W(WE3W), .RdW(RdW),
    .WD3W(WD3W), .FlushE(FlushE), .StallD(StallD), .ValidE(ValidE), .IllegalE(IllegalE),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .Funct3E(Funct3E), .RegWriteE(RegWriteE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE),
    .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic fl);
    InstrD   = i;
    ValidD   = v;
    FlushE   = fl;
    PCD      = 32'h0000_1000;
    PCPlus4D = 32'h0000_1004;
  endtask

  function automatic logic [4:0] pick_reg();
    return (($urandom % 4) == 0) ? 5'($urandom) : 5'($urandom % 4);
  endfunction

  // Build an instruction from chosen fields and a chosen immediate value.
  task automatic gen(output logic [31:0] i, output e_t d);
    int          k;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
    logic [6:0]  bad_op;
    k   = int'($urandom_range(0, 11));
    if (k > 9) k = 2;
    rd  = pick_reg();
    rs1 = pick_reg();
    rs2 = pick_reg();
    f3  = 3'($urandom);
    alt = 1'($urandom);
    imm = 32'd0;
    d   = '0;
    d.valid = 1'b1;
    i = 32'd0;
    case (k)
      0: begin
        alt = alt && (f3 == 3'd0 || f3 == 3'd5);
        i = {alt ? 7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
        d.alu = 4'(alu_tab[f3] + int'(alt));
        d.rw = 1; d.use1 = 1; d.use2 = 1; d.chk_alu = 1; d.chk_srca = 1; d.chk_srcb = 1;
      end
      1: begin
        if (f3 == 3'd1) begin
          imm = 32'($urandom_range(0, 31)); alt = 0;
        end else if (f3 == 3'd5) begin
          imm = (alt ? 32'h400 : 32'h0) + 32'($urandom_range(0, 31));
        end else begin
          imm = 32'(int'($urandom_range(0, 4095)) - 2048); alt = 0;
        end
        i = {imm[11:0], rs1, f3, rd, 7'h13};
        d.alu = 4'(alu_tab[f3] + int'(f3 == 3'd5 && alt));
        d.rw = 1; d.use1 = 1; d.srcb = 1; d.chk_alu = 1; d.chk_srca = 1; d.chk_srcb = 1;
      end
      2: begin
        imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        i = {imm[11:0], rs1, f3, rd, 7'h03};
        d.rw = 1; d.use1 = 1; d.srcb = 1; d.rsrc = 2'b01; d.alu = 4'd0;
        d.chk_alu = 1; d.chk_srca = 1; d.chk_srcb = 1;
      end
      3: begin
        imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        i = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
        d.mw = 1; d.use1 = 1; d.use2 = 1; d.srcb = 1; d.chk_srcb = 1;
      end
      4: begin
        imm = 32'(2 * (int'($urandom_range(0, 4095)) - 2048));
        i = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
        d.br = 1; d.use1 = 1; d.use2 = 1; d.alu = 4'd1;
        d.chk_alu = 1; d.chk_srca = 1; d.chk_srcb = 1;
      end
      5: begin
        imm = 32'(2 * (int'($urandom_range(0, 1048575)) - 524288));
        i = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
        d.jmp = 1; d.rw = 1; d.rsrc = 2'b10;
      end
      6: begin
        imm = 32'(int'($urandom_range(0, 4095)) - 2048);
        i = {imm[11:0], rs1, 3'b000, rd, 7'h67};
        d.jmp = 1; d.jalr = 1; d.rw = 1; d.rsrc = 2'b10; d.use1 = 1; d.srcb = 1;
        d.alu = 4'd0; d.chk_alu = 1; d.chk_srcb = 1;
      end
      7: begin
        imm = $urandom & 32'hFFFF_F000;
        i = {imm[31:12], rd, 7'h37};
        d.rw = 1; d.srcb = 1; d.alu = 4'd10; d.chk_alu = 1; d.chk_srcb = 1;
      end
      8: begin
        imm = $urandom & 32'hFFFF_F000;
        i = {imm[31:12], rd, 7'h17};
        d.rw = 1; d.srca = 1; d.srcb = 1; d.alu = 4'd0;
        d.chk_alu = 1; d.chk_srca = 1; d.chk_srcb = 1;
      end
      default: begin
        case ($urandom % 4)
          0:       bad_op = 7'h7F;
          1:       bad_op = 7'h0F;
          2:       bad_op = 7'h73;
          default: bad_op = 7'h00;
        endcase
        i = {25'($urandom), bad_op};
        d.illegal = 1;
      end
    endcase
    d.imm = imm;
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    d.rd  = i[11:7];
    d.f3  = i[14:12];
  endtask

  task automatic cmp(input e_t x);
    chk("ValidE",    32'(ValidE),    32'(x.valid));
    chk("IllegalE",  32'(IllegalE),  32'(x.illegal));
    chk("RegWriteE", 32'(RegWriteE), 32'(x.rw));
    chk("MemWriteE", 32'(MemWriteE), 32'(x.mw));
    chk("BranchE",   32'(BranchE),   32'(x.br));
    chk("JumpE",     32'(JumpE),     32'(x.jmp));
    chk("JalrE",     32'(JalrE),     32'(x.jalr));
    if (x.valid && !x.illegal) begin
      chk("ResultSrcE", 32'(ResultSrcE), 32'(x.rsrc));
      chk("PCE",        PCE,      x.pc);
      chk("PCPlus4E",   PCPlus4E, x.pc4);
      chk("ImmExtE",    ImmExtE,  x.imm);
      if (x.chk_alu)  chk("ALUControlE", 32'(ALUControlE), 32'(x.alu));
      if (x.chk_srca) chk("ALUSrcAE",    32'(ALUSrcAE),    32'(x.srca));
      if (x.chk_srcb) chk("ALUSrcBE",    32'(ALUSrcBE),    32'(x.srcb));
    end
    if (x.rw) chk("RdE", 32'(RdE), 32'(x.rd));
    if (x.use1) begin
      chk("Rs1E",    32'(Rs1E),    32'(x.rs1));
      chk("RD1E",    RD1E,         x.rd1);
      chk("Funct3E", 32'(Funct3E), 32'(x.f3));
    end
    if (x.use2) begin
      chk("Rs2E", 32'(Rs2E), 32'(x.rs2));
      chk("RD2E", RD2E,      x.rd2);
    end
    if (!x.valid)
      chk("bubble_data", 32'(|{PCE, PCPlus4E, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, Funct3E,
                               ALUSrcAE, ALUSrcBE, ResultSrcE, ALUControlE}), 32'd0);
  endtask

  initial begin
    reset = 1; WE3W = 0; RdW = 0; WD3W = 0; RD1 = 0; RD2 = 0;
    drive(32'hFFF0_0293, 1'b1, 1'b0);
    step(); step();
    chk("rst_ValidE", 32'(ValidE), 0);
    chk("rst_RegWriteE", 32'(RegWriteE), 0);
    chk("rst_ImmExtE", ImmExtE, 0);
    chk("rst_RdE", 32'(RdE), 0);
    chk("rst_StallD", 32'(StallD), 0);

    reset = 0;
    step();
    chk("addi_ValidE", 32'(ValidE), 1);
    chk("addi_ImmExtE", ImmExtE, 32'hFFFF_FFFF);
    chk("addi_RdE", 32'(RdE), 5);
    chk("addi_ALU", 32'(ALUControlE), 0);
    chk("addi_ALUSrcB", 32'(ALUSrcBE), 1);
    chk("addi_RegWriteE", 32'(RegWriteE), 1);

    drive(32'hFE00_0EE3, 1'b1, 1'b0);
    step();
    chk("beq_ImmExtE", ImmExtE, 32'hFFFF_FFFC);
    chk("beq_BranchE", 32'(BranchE), 1);
    chk("beq_RegWriteE", 32'(RegWriteE), 0);
    chk("beq_ALU", 32'(ALUControlE), 1);

    drive(32'h0003_8433, 1'b1, 1'b0);
    RD1 = 32'h11; WE3W = 1; RdW = 7; WD3W = 32'hABCD;
    step();
    chk("bypass_hit", RD1E, 32'hABCD);
    RdW = 0;
    step();
    chk("bypass_x0", RD1E, 32'h11);
    WE3W = 0;

    drive(32'h0000_A183, 1'b1, 1'b0);
    step();
    drive(32'h0021_8233, 1'b1, 1'b0);
    #1;
    chk("lu_StallD", 32'(StallD), 1);
    step();
    chk("lu_bubble_ValidE", 32'(ValidE), 0);
    chk("lu_StallD_clear", 32'(StallD), 0);
    step();
    chk("lu_add_ValidE", 32'(ValidE), 1);
    chk("lu_add_Rs1E", 32'(Rs1E), 3);
    chk("lu_add_RdE", 32'(RdE), 4);

    drive(32'h0000_A183, 1'b1, 1'b0);
    step();
    drive(32'h0001_81B7, 1'b1, 1'b0);
    #1;
    chk("lui_no_stall", 32'(StallD), 0);
    step();
    chk("lui_ValidE", 32'(ValidE), 1);
    chk("lui_RdE", 32'(RdE), 3);

    drive(32'h0020_A023, 1'b1, 1'b1);
    step();
    chk("flush_ValidE", 32'(ValidE), 0);
    chk("flush_MemWriteE", 32'(MemWriteE), 0);

    drive(32'h0000_A183, 1'b1, 1'b0);
    step();
    drive(32'h0021_8233, 1'b1, 1'b1);
    #1;
    chk("fs_StallD", 32'(StallD), 1);
    step();
    chk("fs_bubble", 32'(ValidE), 0);
    FlushE = 0;
    #1;
    chk("fs_StallD_clear", 32'(StallD), 0);
    step();
    chk("fs_add_ValidE", 32'(ValidE), 1);
    chk("fs_add_Rs1E", 32'(Rs1E), 3);

    drive(32'h0000_007F, 1'b1, 1'b0);
    step();
    chk("ill_IllegalE", 32'(IllegalE), 1);
    chk("ill_ValidE", 32'(ValidE), 1);
    chk("ill_RegWriteE", 32'(RegWriteE), 0);
    chk("ill_MemWriteE", 32'(MemWriteE), 0);

    reset = 1;
    step();
    reset = 0;
    m_e  = '0;
    hold = 0;
    d_desc = '0;
    for (int it = 0; it < 600; it++) begin
      if (!hold) begin
        gen(ins, d_desc);
        InstrD   = ins;
        ValidD   = ($urandom % 8) != 0;
        PCD      = $urandom & 32'hFFFF_FFFC;
        PCPlus4D = PCD + 32'd4;
      end
      RD1    = (d_desc.rs1 == 5'd0) ? 32'd0 : $urandom;
      RD2    = (d_desc.rs2 == 5'd0) ? 32'd0 : $urandom;
      WE3W   = 1'($urandom);
      RdW    = 5'($urandom % 4);
      WD3W   = $urandom;
      FlushE = ($urandom % 6) == 0;
      reset  = ($urandom % 40) == 0;
      #2;
      exp_stall = ValidD && m_e.rw && (m_e.rsrc == 2'b01) && (m_e.rd != 5'd0) &&
                  ((d_desc.use1 && d_desc.rs1 == m_e.rd) || (d_desc.use2 && d_desc.rs2 == m_e.rd));
      chk("StallD", 32'(StallD), 32'(exp_stall));
      b1 = (WE3W && RdW != 5'd0 && RdW == d_desc.rs1) ? WD3W : RD1;
      b2 = (WE3W && RdW != 5'd0 && RdW == d_desc.rs2) ? WD3W : RD2;
      if (reset || FlushE || exp_stall || !ValidD) begin
        nxt = '0;
      end else begin
        nxt     = d_desc;
        nxt.pc  = PCD;
        nxt.pc4 = PCPlus4D;
        nxt.rd1 = b1;
        nxt.rd2 = b2;
        nxt.rw  = d_desc.rw && (d_desc.rd != 5'd0);
      end
      step();
      m_e = nxt;
      cmp(m_e);
      hold = exp_stall;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Decode stage of the 5-stage RV32I pipeline. It sits between the IF/ID register and the execute stage. It drives the register-file read addresses, and it bypasses a same-cycle writeback onto the read data. It decodes the instruction into control signals and a sign-extended immediate, detects load-use hazards, and holds the ID/EX pipeline register, including bubble insertion on stall or flush.

## Interface
Parameters:
- none. Fixed RV32I, XLEN 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears the ID/EX register.
- InstrD  in  32  instruction from IF/ID.
- PCD, PCPlus4D  in  32 each  PC and PC+4 of InstrD.
- ValidD  in  1  InstrD is a real instruction; 0 means bubble.
- A1, A2  out  5  register-file read addresses, equal to InstrD[19:15] and InstrD[24:20].
- RD1, RD2  in  32  register-file read data; combinational, x0 reads 0.
- WE3W, RdW, WD3W  in  1/5/32  writeback port, also driven into the register file.
- FlushE  in  1  taken branch or jump resolved in EX; kill the instruction entering E.
- StallD  out  1  load-use stall request to IF and IF/ID (hold).
- ValidE, IllegalE  out  1  E-stage valid flag and unsupported-opcode flag.
- PCE, PCPlus4E, RD1E, RD2E, ImmExtE  out  32 each  E-stage data.
- Rs1E, Rs2E, RdE  out  5  E-stage register indices, for EX forwarding.
- Funct3E  out  3  for branch compare and load/store size.
- RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcAE, ALUSrcBE  out  1  controls.
  - ALUSrcAE: 1 selects PCE.
  - ALUSrcBE: 1 selects ImmExtE.
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUControlE  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.

## Operation
- **Bypass.** If WE3W and RdW!=0 and RdW==A1, the effective RS1 value is WD3W; otherwise it is RD1. RS2 is handled the same way against A2.
- **Decode by opcode:**
  - OP: R-type. SUB when funct7[5]=1 with funct3=000. SRA when funct7[5]=1 with funct3=101.
  - OP-IMM: I-type. SRAI when funct7[5]=1 with funct3=101.
  - LOAD: ADD, ResultSrc 01.
  - STORE: MemWrite, RegWrite 0.
  - BRANCH: Branch, SUB, RegWrite 0.
  - JAL: Jump, ResultSrc 10.
  - JALR: Jalr, Jump, ADD, ResultSrc 10.
  - LUI: PASSB.
  - AUIPC: ADD, ALUSrcA 1.
- **Immediates**, sign-extended from InstrD[31]: I, S, B (bit0=0), U (low 12 bits zero), J (bit0=0). R-type immediate is 0.
- **Unsupported opcode:** IllegalE=1, ValidE=1, all write, branch and jump controls 0.
- **Source usage:**
  - rs1 is used by R, I, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by R, STORE, BRANCH.
  - Unused sources never cause a stall.
- **Load-use hazard.** StallD=1 when all of the following hold:
  - ValidD is 1.
  - ResultSrcE==01 and RegWriteE==1.
  - RdE!=0.
  - RdE matches a used source of InstrD.
  
  StallD is combinational from current E state and InstrD.
- **ID/EX update priority** at each rising edge:
  1. reset: all E outputs 0.
  2. Else FlushE or StallD: insert a bubble. All E outputs 0, so ValidE, RegWriteE, MemWriteE, BranchE, JumpE, JalrE and IllegalE are 0.
  3. Else: load the decoded InstrD. If ValidD=0, load a bubble.
- RegWriteE is forced to 0 when rd=0.

## Timing
- Decode, bypass and StallD are combinational in D. E outputs appear 1 cycle after the instruction is present in D.
- The instruction is held in D while StallD=1. Exactly one bubble is inserted per load-use hazard. The next cycle, the load sits in M, StallD deasserts, and EX forwarding covers the dependency.
- FlushE together with StallD produces a single bubble. Upstream flush of D is the hazard controller's job.
- Reset asserted mid-stream clears E in the same edge. StallD reads 0 in the cycle after reset because E is empty.
- The bypass covers the write-then-read-same-cycle case. The register file writes at the edge, so no stale read reaches E.

## Test plan
- **Reset:** hold reset for 2 cycles with valid ADDI in D → all E outputs 0, StallD=0.
- **Decode:** `addi x5,x0,-1` (0xFFF00293) → next cycle ImmExtE=0xFFFFFFFF, RdE=5, ALUControlE=0, ALUSrcBE=1, RegWriteE=1. Also check one of each type, for example the B-immediate of `beq` offset -4 → ImmExtE=0xFFFFFFFC.
- **Bypass:** RD1=0x11, WE3W=1, RdW=A1=7, WD3W=0xABCD → RD1E=0xABCD. With RdW=0 → RD1E=0x11.
- **Load-use:** `lw x3,0(x1)` followed by `add x4,x3,x2`:
  - StallD=1 for 1 cycle and a bubble enters E (ValidE=0).
  - The `add` reaches E next, with Rs1E=3.
  - `lui x3` after the load causes no stall.
- **Flush:** FlushE=1 on the same edge as a valid `sw` → ValidE=0, MemWriteE=0. Flush during stall → one bubble only.
- **Illegal:** opcode 0x7F → IllegalE=1, RegWriteE=0, MemWriteE=0.
